mod_n_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 26 ++
 rtl/tick_gen.sv | 52 +++++
 rtl/mod_n_counter.sv | 117 +++++++++++
 tb/tb_mod_n_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
// Shared types and helpers for the modulo-N counter and its tick prescaler.
//   dir_t   : count direction encoding of the up_dn input
//   mode_t  : limit behaviour encoding of the sat_mode input
//   div_of  : prescaler division ratio from clock and step frequencies
// ----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_t;

    // Returns 0 for a zero step rate so the elaboration check on DIV trips
    // instead of a divide-by-zero.
    function automatic int div_of(input int clk_hz, input int tick_hz);
        return (tick_hz > 0) ? (clk_hz / tick_hz) : 0;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Prescaler producing a registered single-cycle clock-enable pulse every DIV
// cycles. No derived clock is generated.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   clr      in   synchronous restart of the prescaler (pulse suppressed)
//   tick_out out  one-cycle pulse, high the cycle after the prescaler hit DIV-1
// ----------------------------------------------------------------------------
module tick_gen #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick_out
);

    // DIV = 1 still needs a 1-bit register; it simply stays at 0 and the
    // terminal compare is then always true, giving a tick every cycle.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("tick_gen: DIV must be >= 1");
    end

    logic [PW-1:0] presc_reg;
    logic [PW-1:0] presc_next;
    logic          tick_reg;

    always_comb begin
        presc_next = (presc_reg == LAST) ? '0 : presc_reg + PW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
            tick_reg  <= 1'b0;
        end else if (clr) begin
            presc_reg <= '0;
            tick_reg  <= 1'b0;
        end else begin
            presc_reg <= presc_next;
            tick_reg  <= (presc_reg == LAST);
        end
    end

    assign tick_out = tick_reg;

endmodule

// File: rtl/mod_n_counter.sv
// ----------------------------------------------------------------------------
// mod_n_counter
// Modulo-N up/down counter stepped by an integrated tick prescaler.
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset
//   ena       in   count enable (prescaler runs regardless)
//   up_dn     in   1 = up, 0 = down
//   sat_mode  in   0 = wrap at limits, 1 = saturate at limits
//   clr       in   synchronous clear of count and prescaler
//   load      in   synchronous load strobe (beats a coincident step)
//   load_val  in   value to load, clamped to MODULUS-1
//   tick_out  out  registered prescaler pulse
//   count     out  current count
//   wrap      out  registered one-cycle wrap/borrow pulse, aligned with count
//   at_max    out  count == MODULUS-1 (combinational)
//   at_zero   out  count == 0 (combinational)
// ----------------------------------------------------------------------------
module mod_n_counter
    import counter_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1,
    parameter int MODULUS = 12,
    parameter int WIDTH   = $clog2(MODULUS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tick_out,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_max,
    output logic             at_zero
);

    localparam int DIV = div_of(CLK_HZ, TICK_HZ);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS itself is representable when it is 2**WIDTH.
    localparam logic [WIDTH:0]   MOD_W1  = (WIDTH + 1)'(MODULUS);

    if (MODULUS < 2) begin : g_bad_mod
        $error("mod_n_counter: MODULUS must be >= 2");
    end
    if (DIV < 1) begin : g_bad_div
        $error("mod_n_counter: CLK_HZ/TICK_HZ must be >= 1");
    end

    logic             tick;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic [WIDTH-1:0] load_clamped;
    logic             step;

    tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .tick_out (tick)
    );

    assign step         = tick & ena;
    assign load_clamped = ({1'b0, load_val} >= MOD_W1) ? MAX_VAL : load_val;

    always_comb begin
        count_next = count_reg;
        wrap_next  = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_clamped;
        end else if (step) begin
            if (dir_t'(up_dn) == DIR_UP) begin
                if (count_reg != MAX_VAL) begin
                    count_next = count_reg + WIDTH'(1);
                end else if (mode_t'(sat_mode) == MODE_WRAP) begin
                    count_next = '0;
                    wrap_next  = 1'b1;
                end
            end else begin
                if (count_reg != '0) begin
                    count_next = count_reg - WIDTH'(1);
                end else if (mode_t'(sat_mode) == MODE_WRAP) begin
                    count_next = MAX_VAL;
                    wrap_next  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
            wrap_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            wrap_reg  <= wrap_next;
        end
    end

    assign tick_out = tick;
    assign count    = count_reg;
    assign wrap     = wrap_reg;
    assign at_max   = (count_reg == MAX_VAL);
    assign at_zero  = (count_reg == '0);

endmodule

// File: tb/tb_mod_n_counter.sv
module tb_mod_n_counter;

    localparam int MODULUS = 12;
    localparam int W       = 4;
    localparam int DIVB    = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic         up_dn = 1'b1;
    logic         sat_mode = 1'b0;
    logic         clr = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         tick_out;
    logic [W-1:0] count;
    logic         wrap;
    logic         at_max;
    logic         at_zero;

    mod_n_counter #(
        .CLK_HZ  (8),
        .TICK_HZ (1),
        .MODULUS (MODULUS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .up_dn    (up_dn),
        .sat_mode (sat_mode),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .tick_out (tick_out),
        .count    (count),
        .wrap     (wrap),
        .at_max   (at_max),
        .at_zero  (at_zero)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] count;
        logic         tick;
        logic         wrap;
    } exp_t;

    exp_t sb_q[$];

    int n_vec  = 0;
    int n_miss = 0;

    // reference model state
    int           m_presc = 0;
    logic         m_tick  = 1'b0;
    logic [W-1:0] m_count = '0;
    logic         m_wrap  = 1'b0;

    int wrap_seen;
    int wait_cyc;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one edge using the current inputs, queue the
    // expected outputs, take the edge and compare once outputs settle.
    task automatic cycle();
        exp_t         e;
        exp_t         got;
        int           np;
        logic         nt;
        logic         nw;
        logic [W-1:0] nc;
        if (rst) begin
            np = 0; nt = 1'b0; nc = '0; nw = 1'b0;
        end else begin
            if (clr) begin
                np = 0; nt = 1'b0;
            end else begin
                nt = (m_presc == DIVB - 1);
                np = (m_presc == DIVB - 1) ? 0 : m_presc + 1;
            end
            nw = 1'b0;
            nc = m_count;
            if (clr) begin
                nc = '0;
            end else if (load) begin
                nc = (int'(load_val) >= MODULUS) ? W'(MODULUS - 1) : load_val;
            end else if (m_tick && ena) begin
                if (up_dn) begin
                    if (int'(m_count) < MODULUS - 1) nc = m_count + 1'b1;
                    else if (!sat_mode) begin nc = '0; nw = 1'b1; end
                end else begin
                    if (m_count > 0) nc = m_count - 1'b1;
                    else if (!sat_mode) begin nc = W'(MODULUS - 1); nw = 1'b1; end
                end
            end
        end
        m_presc = np; m_tick = nt; m_count = nc; m_wrap = nw;
        e.count = nc; e.tick = nt; e.wrap = nw;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check_val("count",   int'(count),    int'(got.count));
        check_val("tick",    int'(tick_out), int'(got.tick));
        check_val("wrap",    int'(wrap),     int'(got.wrap));
        check_val("at_max",  int'(at_max),   int'(got.count == W'(MODULUS - 1)));
        check_val("at_zero", int'(at_zero),  int'(got.count == '0));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = W'(v);
        cycle();
        load = 1'b0;
    endtask

    initial begin
        // reset held over a few edges
        run(3);
        rst = 1'b0;

        // 1: bring count to 5 mid-prescale, then async reset between edges
        do_load(5);
        run(3);
        check_val("pre_rst_count", int'(count), 5);
        #3;
        rst = 1'b1;
        #1;
        check_val("async_rst_count", int'(count), 0);
        check_val("async_rst_tick",  int'(tick_out), 0);
        check_val("async_rst_wrap",  int'(wrap), 0);
        m_presc = 0; m_tick = 1'b0; m_count = '0; m_wrap = 1'b0;
        cycle();
        rst = 1'b0;
        wait_cyc = -1;
        for (int i = 1; i <= 20 && wait_cyc < 0; i++) begin
            cycle();
            if (tick_out) wait_cyc = i;
        end
        check_val("first_tick_after_rst", wait_cyc, DIVB);

        // 2: up wrap across a full revolution
        ena = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
        wrap_seen = 0;
        for (int i = 0; i < 96; i++) begin
            cycle();
            if (wrap) begin
                wrap_seen++;
                check_val("wrap_at_zero", int'(count), 0);
            end
        end
        check_val("up_wrap_pulses", wrap_seen, 1);
        check_val("up_wrap_end", int'(count), 0);

        // 3: down wrap from 0 then a normal down step
        up_dn = 1'b0;
        run(8);
        check_val("down_wrap_count", int'(count), MODULUS - 1);
        run(8);
        check_val("down_step_count", int'(count), MODULUS - 2);

        // 4: saturate at both limits
        sat_mode = 1'b1; up_dn = 1'b1;
        do_load(11);
        run(16);
        check_val("sat_hi", int'(count), 11);
        up_dn = 1'b0;
        do_load(0);
        run(16);
        check_val("sat_lo", int'(count), 0);
        sat_mode = 1'b0;

        // 5: loads: plain, clamped, coincident with a step, and hold with ena=0
        ena = 1'b0;
        while (m_tick) cycle();
        do_load(7);
        check_val("load7", int'(count), 7);
        do_load(15);
        check_val("load_clamp", int'(count), 11);
        do_load(3);
        for (int i = 0; i < 20 && !m_tick; i++) cycle();
        check_val("tick_found", int'(m_tick), 1);
        ena = 1'b1; up_dn = 1'b1;
        do_load(9);
        check_val("load_beats_step", int'(count), 9);
        ena = 1'b0;
        run(24);
        check_val("ena_hold", int'(count), 9);

        // 6: clear at prescaler 5, then tick spacing and clr over load
        for (int i = 0; i < 20 && m_presc != 5; i++) cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        check_val("clr_count", int'(count), 0);
        wait_cyc = -1;
        for (int i = 1; i <= 20 && wait_cyc < 0; i++) begin
            cycle();
            if (tick_out) wait_cyc = i;
        end
        check_val("tick_after_clr", wait_cyc, DIVB);
        do_load(6);
        clr = 1'b1; load = 1'b1; load_val = 4'd10;
        cycle();
        clr = 1'b0; load = 1'b0;
        check_val("clr_over_load", int'(count), 0);
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
